// File: rtl/i2s_tx_master_pkg.sv
// Shared I2S constants for the transmit master and the mic receiver.
// Frame geometry and the BCLK divider ratio for a 25 MHz system clock.
package i2s_tx_master_pkg;

    localparam int I2S_SLOT_W        = 32;
    localparam int I2S_FRAME_W       = 2 * I2S_SLOT_W;
    localparam int I2S_DATA_W        = 24;
    localparam int I2S_BCLK_HALF_25M = 4;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_tx_master_clk_gen.sv
// I2S master clock generator: BCLK divider, frame bit counter and LRCLK.
// Shared with the receiver when it runs as bus master.
// Ports:
//   clk_25m   in   system clock
//   rst       in   synchronous reset, active-high
//   bclk      out  bit clock, registered
//   lrclk     out  word select, 0 = left slot, 1 = right slot
//   fall_stb  out  high in the cycle whose clock edge drives bclk 1->0
//   frame_stb out  fall_stb on the last bit of the frame (bit_cnt wraps to 0)
//   bit_cnt   out  index of the frame bit currently on the bus
module i2s_tx_master_clk_gen
    import i2s_tx_master_pkg::*;
#(
    parameter int  SLOT_W    = I2S_SLOT_W,
    parameter int  BCLK_HALF = I2S_BCLK_HALF_25M,
    localparam int FRAME_W   = 2 * SLOT_W,
    localparam int CNT_W     = cnt_width(FRAME_W),
    localparam int DIV_W     = cnt_width(BCLK_HALF)
) (
    input  logic             clk_25m,
    input  logic             rst,
    output logic             bclk,
    output logic             lrclk,
    output logic             fall_stb,
    output logic             frame_stb,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             div_wrap;

    always_comb begin
        div_wrap  = (div_cnt_q == DIV_W'(BCLK_HALF - 1));
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d    = div_wrap ? ~bclk_q : bclk_q;
        fall_stb  = div_wrap && bclk_q;
        frame_stb = fall_stb && (bit_cnt_q == CNT_W'(FRAME_W - 1));
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        if (fall_stb) begin
            bit_cnt_d = frame_stb ? '0 : bit_cnt_q + CNT_W'(1);
            lrclk_d   = (bit_cnt_d >= CNT_W'(SLOT_W));
        end
    end

    // bit_cnt starts on the last bit so the very first fall opens a left slot.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= CNT_W'(FRAME_W - 1);
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
        end
    end

    assign bclk    = bclk_q;
    assign lrclk   = lrclk_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/i2s_tx_master.sv
// I2S bus master / transmitter for the speaker amplifier path.
// Takes one stereo pair per frame through valid/ready and shifts it out MSB
// first in I2S format (one BCLK delay after each LRCLK edge).
// Ports:
//   clk_25m      in   system clock
//   rst          in   synchronous reset, active-high
//   s_valid      in   stereo pair present on s_left/s_right
//   s_ready      out  holding register empty
//   s_left       in   left sample, two's complement
//   s_right      in   right sample, two's complement
//   i2s_bclk     out  bit clock
//   i2s_lrclk    out  word select, 0 = left
//   i2s_dout     out  serial data, changes on BCLK fall
//   frame_start  out  strobe in the cycle that opens a new frame
//   underrun     out  strobe when a frame opens with no pair pending
module i2s_tx_master
    import i2s_tx_master_pkg::*;
#(
    parameter int DATA_W    = I2S_DATA_W,
    parameter int SLOT_W    = I2S_SLOT_W,
    parameter int BCLK_HALF = I2S_BCLK_HALF_25M
) (
    input  logic              clk_25m,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_dout,
    output logic              frame_start,
    output logic              underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = cnt_width(FRAME_W);
    localparam int PAD_W   = SLOT_W - 1 - DATA_W;

    logic               fall_stb, frame_stb, boundary, accept;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SLOT_W-1:0]  slot_l, slot_r;
    logic [FRAME_W-1:0] next_word;

    logic               hold_full_q, hold_full_d;
    logic [DATA_W-1:0]  hold_l_q, hold_l_d;
    logic [DATA_W-1:0]  hold_r_q, hold_r_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               dout_q, dout_d;
    logic               s_ready_q, s_ready_d;

    i2s_tx_master_clk_gen #(
        .SLOT_W    (SLOT_W),
        .BCLK_HALF (BCLK_HALF)
    ) u_clk_gen (
        .clk_25m   (clk_25m),
        .rst       (rst),
        .bclk      (i2s_bclk),
        .lrclk     (i2s_lrclk),
        .fall_stb  (fall_stb),
        .frame_stb (frame_stb),
        .bit_cnt   (bit_cnt)
    );

    always_comb begin
        accept   = s_valid && s_ready_q;
        boundary = frame_stb && (bit_cnt == CNT_W'(FRAME_W - 1));

        // Each slot is {delay bit, sample, zero pad}; the zero-extended sample
        // shifted up by the pad width leaves the delay bit at the slot MSB.
        slot_l    = {{(SLOT_W - DATA_W){1'b0}}, hold_l_q} << PAD_W;
        slot_r    = {{(SLOT_W - DATA_W){1'b0}}, hold_r_q} << PAD_W;
        next_word = hold_full_q ? {slot_l, slot_r} : '0;

        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        shift_d     = shift_q;
        dout_d      = dout_q;

        // At the boundary frame bit 0 goes straight to the pin, so the shift
        // register keeps only the remaining bits.
        if (boundary) begin
            hold_full_d = 1'b0;
            dout_d      = next_word[FRAME_W-1];
            shift_d     = next_word << 1;
        end else if (fall_stb) begin
            dout_d  = shift_q[FRAME_W-1];
            shift_d = shift_q << 1;
        end

        // Accept needs s_ready, which is low whenever a boundary could drain
        // the holding register, so the two never collide on a full register.
        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = s_left;
            hold_r_d    = s_right;
        end

        s_ready_d = !hold_full_d;
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shift_q     <= '0;
            dout_q      <= 1'b0;
            s_ready_q   <= 1'b1;
        end else begin
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            s_ready_q   <= s_ready_d;
        end
    end

    // Strobes are decoded from registered state; gating with rst keeps a
    // reset that lands on a boundary from reporting a frame.
    assign frame_start = boundary && !rst;
    assign underrun    = boundary && !hold_full_q && !rst;
    assign s_ready     = s_ready_q;
    assign i2s_dout    = dout_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
module tb_i2s_tx_master;

    logic        clk_25m = 1'b0;
    logic        rst     = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_left  = '0;
    logic [23:0] s_right = '0;
    logic        i2s_bclk, i2s_lrclk, i2s_dout, frame_start, underrun;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] word;
        bit          ur;
    } exp_t;

    exp_t exp_q[$];

    i2s_tx_master dut (
        .clk_25m     (clk_25m),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_dout    (i2s_dout),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #20 clk_25m = ~clk_25m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mkword(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    task automatic push(input logic [63:0] w, input bit ur);
        exp_t e;
        e.word = w;
        e.ur   = ur;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_25m);
        #1;
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        while (!frame_start && n < 1200) begin
            step();
            n++;
        end
        if (!frame_start) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no frame_start within %0d cycles", tag, n);
        end
    endtask

    task automatic offer(input logic [23:0] l, input logic [23:0] r,
                         output int waited, output bit fs_before);
        s_valid   = 1'b1;
        s_left    = l;
        s_right   = r;
        waited    = 0;
        fs_before = 1'b0;
        while (!s_ready && waited < 1200) begin
            fs_before = frame_start;
            step();
            waited++;
        end
        if (!s_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL offer_timeout: s_ready got 0 expected 1 after %0d cycles", waited);
        end
        step();
    endtask

    // Monitor: rebuilds each frame from dout sampled on BCLK rise and
    // compares it with the scoreboard entry popped when that frame opened.
    logic        bclk_prev = 1'b0;
    bit          active    = 1'b0;
    int          nbits     = 0;
    logic [63:0] rx        = '0;
    exp_t        cur;

    always @(negedge clk_25m) begin
        if (rst) begin
            active = 1'b0;
            nbits  = 0;
        end else begin
            if (i2s_bclk && !bclk_prev && active) begin
                check("lrclk_slot", i2s_lrclk, (nbits >= 32));
                rx = {rx[62:0], i2s_dout};
                nbits++;
            end
            if (frame_start) begin
                if (active) begin
                    check("frame_bits", nbits, 64);
                    check("frame_word", rx, cur.word);
                end
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: got frame_start expected none");
                    active = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    check("frame_underrun", underrun, cur.ur);
                    active = 1'b1;
                    nbits  = 0;
                    rx     = '0;
                end
            end
        end
        bclk_prev = i2s_bclk;
    end

    initial begin
        int  cnt;
        bit  prev_lr;
        int  waited;
        bit  fs_before;

        // Reset values, then idle frames.
        repeat (3) step();
        check("rst_bclk", i2s_bclk, 0);
        check("rst_lrclk", i2s_lrclk, 1);
        check("rst_dout", i2s_dout, 0);
        check("rst_ready", s_ready, 1);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);

        push(64'h0, 1'b1);
        push(64'h0, 1'b1);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 3) check("a_bclk_k3", i2s_bclk, 0);
            if (k == 4) check("a_bclk_rise", i2s_bclk, 1);
            if (k == 7) begin
                check("a_fs_k7", frame_start, 1);
                check("a_ur_k7", underrun, 1);
                check("a_lrclk_k7", i2s_lrclk, 1);
            end
            if (k == 8) begin
                check("a_bclk_fall", i2s_bclk, 0);
                check("a_lrclk_fall", i2s_lrclk, 0);
                check("a_fs_k8", frame_start, 0);
            end
        end

        cnt     = 0;
        prev_lr = i2s_lrclk;
        while (cnt < 2000) begin
            step();
            cnt++;
            if (prev_lr && !i2s_lrclk) break;
            prev_lr = i2s_lrclk;
        end
        check("lrclk_period", cnt, 512);

        // Mid right slot reset (bit_cnt = 40).
        repeat (322) step();
        rst = 1'b1;
        step();
        check("mid_rst_bclk", i2s_bclk, 0);
        check("mid_rst_lrclk", i2s_lrclk, 1);
        check("mid_rst_dout", i2s_dout, 0);
        check("mid_rst_ready", s_ready, 1);
        check("mid_rst_fs", frame_start, 0);
        check("mid_rst_ur", underrun, 0);

        push(mkword(24'hABCDEF, 24'h123456), 1'b0);
        push(mkword(24'h000001, 24'hFFFFFF), 1'b0);
        push(mkword(24'h5A5A5A, 24'hA5A5A5), 1'b0);
        push(mkword(24'h7FFFFF, 24'h000000), 1'b0);
        push(64'h0, 1'b1);
        push(mkword(24'h3C3C3C, 24'hC3C3C3), 1'b0);
        push(mkword(24'h800000, 24'h7FFFFF), 1'b0);
        push(64'h0, 1'b1);
        rst = 1'b0;

        // Restart timing plus a pair sent before the first boundary.
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                check("b_bclk_k1", i2s_bclk, 0);
                s_valid = 1'b1;
                s_left  = 24'hABCDEF;
                s_right = 24'h123456;
            end
            if (k == 2) begin
                check("b_ready_after_accept", s_ready, 0);
                s_valid = 1'b0;
                s_left  = 24'hFFFFFF;
            end
            if (k == 4) check("b_bclk_rise", i2s_bclk, 1);
            if (k == 7) begin
                check("b_fs_k7", frame_start, 1);
                check("b_ur_k7", underrun, 0);
            end
            if (k == 8) begin
                check("b_bclk_fall", i2s_bclk, 0);
                check("b_lrclk_fall", i2s_lrclk, 0);
                check("b_ready_reopen", s_ready, 1);
            end
        end

        // Back-to-back stream with s_valid held high.
        offer(24'h000001, 24'hFFFFFF, waited, fs_before);
        check("p1_ready_low", s_ready, 0);
        offer(24'h5A5A5A, 24'hA5A5A5, waited, fs_before);
        check("p2_waited", (waited > 0), 1);
        check("p2_reopen_after_fs", fs_before, 1);
        offer(24'h7FFFFF, 24'h000000, waited, fs_before);
        check("p3_waited", (waited > 0), 1);
        check("p3_reopen_after_fs", fs_before, 1);
        s_valid = 1'b0;
        check("p3_ready_low", s_ready, 0);

        // Pair offered exactly in an empty-holding boundary cycle.
        wait_fs("wait_b3");
        step();
        wait_fs("wait_b4");
        check("b4_underrun", underrun, 1);
        s_valid = 1'b1;
        s_left  = 24'h3C3C3C;
        s_right = 24'hC3C3C3;
        step();
        s_valid = 1'b0;
        check("b4_captured", s_ready, 0);

        // Full-scale sign ordering.
        wait_fs("wait_b5");
        step();
        offer(24'h800000, 24'h7FFFFF, waited, fs_before);
        s_valid = 1'b0;
        wait_fs("wait_b6");
        step();
        wait_fs("wait_b7");
        repeat (2) step();
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
